// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM with a shared bidirectional data bus.
// Reads take one address cycle plus one capture cycle; writes take a single drive cycle.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 13,
    parameter int DATA_BUS_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         p0_req,
    input  logic                         p0_we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] p0_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    p0_wdata,
    output logic [DATA_BUS_WIDTH-1:0]    p0_rdata,
    output logic                         p0_done,

    input  logic                         p1_req,
    input  logic                         p1_we,
    input  logic [ADDRESS_BUS_WIDTH-1:0] p1_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    p1_wdata,
    output logic [DATA_BUS_WIDTH-1:0]    p1_rdata,
    output logic                         p1_done,

    output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
    output logic                         mem_read_not_write,
    inout  wire  [DATA_BUS_WIDTH-1:0]    mem_data,
    output logic                         busy,
    output logic                         last_grant
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_ADDR = 2'd1;
    localparam logic [1:0] RD_CAPT = 2'd2;
    localparam logic [1:0] WR      = 2'd3;

    logic [1:0]                   state;
    logic                         p0_eligible;
    logic                         p1_eligible;
    logic                         grant_valid;
    logic                         grant_port;
    logic                         grant_we;
    logic [ADDRESS_BUS_WIDTH-1:0] grant_addr;
    logic [DATA_BUS_WIDTH-1:0]    write_data;

    // A port whose done is high is still holding its finished request; masking it
    // here stops the same request being granted twice.
    always_comb begin
        p0_eligible = p0_req & ~p0_done;
        p1_eligible = p1_req & ~p1_done;
        grant_valid = p0_eligible | p1_eligible;
        grant_port  = (p0_eligible & p1_eligible) ? ~last_grant : p1_eligible;
        grant_we    = grant_port ? p1_we   : p0_we;
        grant_addr  = grant_port ? p1_addr : p0_addr;
        write_data  = last_grant ? p1_wdata : p0_wdata;
    end

    // NOTE: all state below is registered with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_address <= '0;
            last_grant  <= 1'b1;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
        end else begin
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_address <= grant_addr;
                        last_grant  <= grant_port;
                        state       <= grant_we ? WR : RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_CAPT;
                RD_CAPT: begin
                    if (last_grant) begin
                        p1_rdata <= mem_data;
                        p1_done  <= 1'b1;
                    end else begin
                        p0_rdata <= mem_data;
                        p0_done  <= 1'b1;
                    end
                    state <= IDLE;
                end
                WR: begin
                    if (last_grant) p1_done <= 1'b1;
                    else            p0_done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Drive enable and direction both decode from state alone so they switch together.
    assign mem_read_not_write = (state != WR);
    assign mem_data           = (state == WR) ? write_data : {DATA_BUS_WIDTH{1'bz}};
    assign busy               = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a registered-read RAM model on the shared bus,
// hand-computed latencies, arbitration order, reset aborts and a per-port scoreboard.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic [DW-1:0] p0_rdata;
    logic          p0_done;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic [DW-1:0] p1_rdata;
    logic          p1_done;
    logic [AW-1:0] mem_address;
    logic          mem_read_not_write;
    wire  [DW-1:0] mem_data;
    logic          busy;
    logic          last_grant;

    int vectors = 0;
    int miscompares = 0;
    int issued0 = 0, issued1 = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    int order_q[$];
    logic [DW-1:0] model0 [8];
    logic [DW-1:0] model1 [8];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done),
        .mem_address(mem_address), .mem_read_not_write(mem_read_not_write),
        .mem_data(mem_data), .busy(busy), .last_grant(last_grant)
    );

    // RAM model: synchronous write, one-cycle registered read, drives the bus when reading.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic          preload_en = 1'b1;

    always @(posedge clk) begin
        if (preload_en) begin
            ram[4096] <= 32'h0000_0088;
            ram[16]   <= 32'd20;
        end else if (!mem_read_not_write) begin
            ram[mem_address] <= mem_data;
        end
        ram_q <= ram[mem_address];
    end
    assign mem_data = mem_read_not_write ? ram_q : {DW{1'bz}};

    always @(negedge clk) begin
        if (p0_done) begin done_cnt0++; order_q.push_back(0); end
        if (p1_done) begin done_cnt1++; order_q.push_back(1); end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full handshake on port p; exp_lat = 0 skips the latency comparison.
    task automatic access(input int p, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                          input int exp_lat);
        int lat = 0;
        bit seen = 1'b0;
        @(negedge clk);
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd; issued0++;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd; issued1++;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            seen = (p == 0) ? p0_done : p1_done;
        end
        check($sformatf("p%0d done a=%0h", p, a), 32'(seen), 32'd1);
        if (exp_lat != 0)
            check($sformatf("p%0d latency a=%0h", p, a), 32'(lat), 32'(exp_lat));
        if (!we)
            check($sformatf("p%0d rdata a=%0h", p, a), (p == 0) ? p0_rdata : p1_rdata, exp_rd);
        // Keep the request up across the edge where done is high, as a slow requester would.
        @(posedge clk);
        #1;
        if (p == 0) p0_req = 1'b0;
        else        p1_req = 1'b0;
    endtask

    task automatic random_traffic(input int p, input int n);
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int idx;
        bit we;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            a = AW'((p == 0 ? 100 : 200) + i);
            access(p, 1'b1, a, d, '0, 0);
            if (p == 0) model0[i] = d; else model1[i] = d;
        end
        for (int k = 0; k < n; k++) begin
            idx = $urandom_range(0, 7);
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            a   = AW'((p == 0 ? 100 : 200) + idx);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (we) begin
                access(p, 1'b1, a, d, '0, 0);
                if (p == 0) model0[idx] = d; else model1[idx] = d;
            end else begin
                access(p, 1'b0, a, '0, (p == 0) ? model0[idx] : model1[idx], 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload_en = 1'b0;
        #1;
        check("reset busy",       32'(busy),               32'd0);
        check("reset rnw",        32'(mem_read_not_write), 32'd1);
        check("reset mem_address", 32'(mem_address),       32'd0);
        check("reset p0_rdata",   p0_rdata,                32'd0);
        check("reset p1_rdata",   p1_rdata,                32'd0);
        check("reset p0_done",    32'(p0_done),            32'd0);
        check("reset p1_done",    32'(p1_done),            32'd0);
        check("reset last_grant", 32'(last_grant),         32'd1);
        reset_n = 1'b1;

        // Preloaded read, then write/read-back across ports, then top address.
        access(0, 1'b0, 13'd4096, '0, 32'h88, 3);
        check("mem_address held in idle", 32'(mem_address), 32'd4096);
        check("idle rnw", 32'(mem_read_not_write), 32'd1);
        access(1, 1'b1, 13'h30, 32'd42, '0, 2);
        access(0, 1'b0, 13'h30, '0, 32'd42, 3);
        check("p1_rdata untouched", p1_rdata, 32'd0);
        access(1, 1'b1, 13'h1FFF, 32'hDEAD_BEEF, '0, 2);
        access(1, 1'b0, 13'h1FFF, '0, 32'hDEAD_BEEF, 3);
        check("p0_rdata untouched", p0_rdata, 32'd42);

        // Simultaneous requests after p1 was last served: p0 first, then strict alternation.
        order_q.delete();
        fork
            begin
                access(0, 1'b1, 13'h40, 32'd1, '0, 0);
                access(0, 1'b1, 13'h41, 32'd2, '0, 0);
            end
            begin
                access(1, 1'b1, 13'h50, 32'd3, '0, 0);
                access(1, 1'b1, 13'h51, 32'd4, '0, 0);
            end
        join
        check("alt count", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check($sformatf("alt order %0d", i), 32'(order_q[i]), 32'(i % 2));

        // After p0 was served, a simultaneous pair must go to p1 first.
        access(0, 1'b0, 13'h40, '0, 32'd1, 3);
        order_q.delete();
        fork
            access(0, 1'b0, 13'h41, '0, 32'd2, 0);
            access(1, 1'b0, 13'h51, '0, 32'd4, 0);
        join
        check("rr count", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            check("rr first",  32'(order_q[0]), 32'd1);
            check("rr second", 32'(order_q[1]), 32'd0);
        end

        // Reset during RD_CAPT aborts the read.
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 13'd4096;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort rd busy", 32'(busy),               32'd0);
        check("abort rd rnw",  32'(mem_read_not_write), 32'd1);
        p0_req = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort rd no done", 32'(p0_done), 32'd0);
        check("abort rd rdata",   p0_rdata,      32'd0);
        access(0, 1'b0, 13'd4096, '0, 32'h88, 3);

        // Reset during WR must not commit the write.
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 13'd16; p1_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort wr busy", 32'(busy),               32'd0);
        check("abort wr rnw",  32'(mem_read_not_write), 32'd1);
        p1_req = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort wr no done", 32'(p1_done), 32'd0);
        access(0, 1'b0, 13'd16, '0, 32'd20, 3);

        // Concurrent mixed traffic on disjoint address windows.
        fork
            random_traffic(0, 120);
            random_traffic(1, 120);
        join
        repeat (3) @(negedge clk);
        check("p0 done total", 32'(done_cnt0), 32'(issued0));
        check("p1 done total", 32'(done_cnt1), 32'(issued1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDRESS_BUS_WIDTH, default 13: width of the RAM address and of each port address.
REQ-002 Parameter DATA_BUS_WIDTH, default 32: width of the RAM data word and of each port data bus.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with the ram instance.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pN_req  input  1  (N=0,1) port N requests an access; held until pN_done.
REQ-007 pN_we  input  1  port N access type: 1 = write, 0 = read; stable while pN_req is high.
REQ-008 pN_addr  input  ADDRESS_BUS_WIDTH  port N word address; stable while pN_req is high.
REQ-009 pN_wdata  input  DATA_BUS_WIDTH  port N write data; stable while pN_req is high.
REQ-010 pN_rdata  output  DATA_BUS_WIDTH  port N read data, valid while pN_done is high, held afterwards.
REQ-011 pN_done  output  1  registered one-cycle completion pulse for port N.
REQ-012 mem_address  output  ADDRESS_BUS_WIDTH  RAM address, registered.
REQ-013 mem_read_not_write  output  1  RAM direction: 1 = RAM drives mem_data, 0 = write.
REQ-014 mem_data  inout  DATA_BUS_WIDTH  RAM bidirectional data bus.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 last_grant  output  1  index of the port served most recently.

Function
REQ-017 The state machine SHALL have exactly these states: IDLE, RD_ADDR, RD_CAPT, WR.
REQ-018 In IDLE, an eligible request SHALL be granted at the clock edge: mem_address <= pN_addr and last_grant <= N; next state is WR if pN_we=1, otherwise RD_ADDR.
REQ-019 A port SHALL be ineligible in any cycle where its pN_done is high, which prevents a double grant of a request still being held.
REQ-020 If both ports are eligible, grant SHALL go to the port != last_grant (round-robin); a single eligible port SHALL be granted regardless of last_grant.
REQ-021 RD_ADDR SHALL last one cycle with mem_read_not_write=1; the next state is RD_CAPT.
REQ-022 RD_CAPT SHALL last one cycle; at its closing edge pN_rdata <= mem_data, pN_done <= 1, and the state returns to IDLE.
REQ-023 Read latency SHALL be: grant edge + 2 edges -> pN_done high for the following cycle.
REQ-024 WR SHALL last one cycle with mem_read_not_write=0 and mem_data driven with the granted pN_wdata; at its closing edge pN_done <= 1 and the state returns to IDLE.
REQ-025 Write latency SHALL be: grant edge + 1 edge -> pN_done high.
REQ-026 The block SHALL drive mem_data only when the state is WR; otherwise mem_data SHALL be high-Z.
REQ-027 mem_read_not_write SHALL be decoded combinationally from state only (0 iff WR), so that drive and direction switch together.
REQ-028 pN_done SHALL be high for exactly one cycle per grant; the other port's done and rdata SHALL be unaffected.
REQ-029 mem_address SHALL hold its last value in IDLE; addresses SHALL pass through unmodified, with no range check.
REQ-030 A request that arrives during busy SHALL wait; no request SHALL be dropped.
REQ-031 Steady requests from both ports SHALL alternate strictly.

Reset
REQ-032 On reset_n low, asynchronously: state=IDLE, mem_read_not_write=1, mem_data released, mem_address=0, pN_rdata=0, pN_done=0, last_grant=1 (port 0 wins first), busy=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no pN_done; a write aborted before its closing edge SHALL not be committed.
REQ-034 Operation SHALL resume on the first rising edge after reset_n deasserts.

Verification
REQ-035 RAM preloaded word 4096=0x00000088; p0 read of 4096 -> p0_done exactly 3 edges after req is sampled, p0_rdata=0x00000088.
REQ-036 p1 write of 42 to address 0x30, then p0 read of 0x30 -> p1_done 2 edges after sampling; p0_rdata=42.
REQ-037 Both ports assert req together after reset -> p0 is served first, then p1; with both still requesting, the next grant goes to p0 again; the order alternates p0,p1,p0,p1.
REQ-038 reset_n pulsed low during RD_CAPT -> no done, busy=0, mem_read_not_write=1 immediately; the next request completes normally.
REQ-039 reset_n pulsed low during WR of 0x55 to address 16 (old value 20) -> address 16 still reads 20.
REQ-040 Random mixed traffic for 10k cycles -> mem_data never X or contended, every req gets exactly one done, and read data matches a scoreboard.
